// File: rtl/frida_seq_gen.sv
// -----------------------------------------------------------------------------
// frida_seq_gen
// On-chip SAR conversion sequencer. Generates the four phase strobes consumed
// by the ADC array (init, sample, compare, update-logic) from one fast clock.
// Phase widths and compare-cycle count are programmable. Single-shot and
// continuous modes are supported.
//
// Ports
//   clk          sequencer clock, rising edge
//   rst          asynchronous active-high reset
//   start        conversion request, honoured only in IDLE
//   abort        synchronous stop, returns to IDLE without counting
//   cfg_cont     continuous mode, sampled live at conversion completion
//   cfg_t_*      phase widths in clk cycles (0 behaves as 1)
//   cfg_ncmp     compare/logic pairs per conversion (0 behaves as 1)
//   seq_*        one-hot-or-zero phase strobes, registered
//   cmp_idx      current compare index, counts ncmp-1 down to 0
//   busy         high while any phase strobe is active
//   done         one-cycle pulse after the last logic cycle
//   conv_count   completed conversions, wraps at full scale
// -----------------------------------------------------------------------------
module frida_seq_gen #(
   parameter int CNT_W  = 8,
   parameter int NCMP_W = 5,
   parameter int CONV_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cfg_cont,
   input  logic [CNT_W-1:0]  cfg_t_init,
   input  logic [CNT_W-1:0]  cfg_t_samp,
   input  logic [CNT_W-1:0]  cfg_t_cmp,
   input  logic [CNT_W-1:0]  cfg_t_logic,
   input  logic [NCMP_W-1:0] cfg_ncmp,
   output logic              seq_init,
   output logic              seq_samp,
   output logic              seq_cmp,
   output logic              seq_logic,
   output logic [NCMP_W-1:0] cmp_idx,
   output logic              busy,
   output logic              done,
   output logic [CONV_W-1:0] conv_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SAMP,
      S_CMP,
      S_LOGIC
   } state_t;

   function automatic logic [CNT_W-1:0] clamp_w(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   function automatic logic [NCMP_W-1:0] clamp_n(input logic [NCMP_W-1:0] v);
      return (v == '0) ? NCMP_W'(1) : v;
   endfunction

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [NCMP_W-1:0]   r_idx, w_idx_nxt;
   logic [CONV_W-1:0]   r_conv, w_conv_nxt;
   logic                w_done_nxt;
   logic                w_latch;
   logic                w_last;

   // Latched (already clamped) configuration. INIT width is consumed at the
   // latch edge itself, so it needs no holding register.
   logic [CNT_W-1:0]    r_t_samp, r_t_cmp, r_t_logic;
   logic [NCMP_W-1:0]   r_ncmp;

   logic                r_seq_init, r_seq_samp, r_seq_cmp, r_seq_logic;
   logic                r_busy, r_done;

   // r_cnt holds the cycles remaining in the current phase, including this one.
   assign w_last = (r_cnt == CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_conv_nxt  = r_conv;
      w_done_nxt  = 1'b0;
      w_latch     = 1'b0;
      if (r_state != S_IDLE) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt = S_INIT;
                  w_latch     = 1'b1;
                  w_cnt_nxt   = clamp_w(cfg_t_init);
               end
            end
            S_INIT: begin
               if (w_last) begin
                  w_state_nxt = S_SAMP;
                  w_cnt_nxt   = r_t_samp;
                  w_idx_nxt   = r_ncmp - NCMP_W'(1);
               end
            end
            S_SAMP: begin
               if (w_last) begin
                  w_state_nxt = S_CMP;
                  w_cnt_nxt   = r_t_cmp;
               end
            end
            S_CMP: begin
               if (w_last) begin
                  w_state_nxt = S_LOGIC;
                  w_cnt_nxt   = r_t_logic;
               end
            end
            S_LOGIC: begin
               if (w_last) begin
                  if (r_idx != '0) begin
                     w_state_nxt = S_CMP;
                     w_cnt_nxt   = r_t_cmp;
                     w_idx_nxt   = r_idx - NCMP_W'(1);
                  end else begin
                     w_done_nxt = 1'b1;
                     w_conv_nxt = r_conv + CONV_W'(1);
                     // Continuous loop re-enters INIT in the done cycle and
                     // re-latches configuration exactly like a fresh start.
                     if (cfg_cont) begin
                        w_state_nxt = S_INIT;
                        w_latch     = 1'b1;
                        w_cnt_nxt   = clamp_w(cfg_t_init);
                     end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                     end
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_conv      <= '0;
         r_t_samp    <= '0;
         r_t_cmp     <= '0;
         r_t_logic   <= '0;
         r_ncmp      <= '0;
         r_seq_init  <= 1'b0;
         r_seq_samp  <= 1'b0;
         r_seq_cmp   <= 1'b0;
         r_seq_logic <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_conv  <= w_conv_nxt;
         if (w_latch) begin
            r_t_samp  <= clamp_w(cfg_t_samp);
            r_t_cmp   <= clamp_w(cfg_t_cmp);
            r_t_logic <= clamp_w(cfg_t_logic);
            r_ncmp    <= clamp_n(cfg_ncmp);
         end
         // Strobes are registered from the next state so each output comes
         // straight off a flop while still tracking the state exactly.
         r_seq_init  <= (w_state_nxt == S_INIT);
         r_seq_samp  <= (w_state_nxt == S_SAMP);
         r_seq_cmp   <= (w_state_nxt == S_CMP);
         r_seq_logic <= (w_state_nxt == S_LOGIC);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= w_done_nxt;
      end
   end

   assign seq_init   = r_seq_init;
   assign seq_samp   = r_seq_samp;
   assign seq_cmp    = r_seq_cmp;
   assign seq_logic  = r_seq_logic;
   assign busy       = r_busy;
   assign done       = r_done;
   assign cmp_idx    = r_idx;
   assign conv_count = r_conv;

endmodule

// File: tb/tb_frida_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_frida_seq_gen
// Scoreboard bench for frida_seq_gen. Each scenario pushes the expected
// per-cycle output vector {seq_init,seq_samp,seq_cmp,seq_logic,busy,done,
// cmp_idx,conv_count} built from the phase schedule, then pops and compares
// one vector per clock. A second instance with a 3-bit conversion counter
// exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_frida_seq_gen;

   logic        clk;
   logic        rst;
   logic        start, abort, cfg_cont;
   logic [7:0]  cfg_t_init, cfg_t_samp, cfg_t_cmp, cfg_t_logic;
   logic [4:0]  cfg_ncmp;
   logic        seq_init, seq_samp, seq_cmp, seq_logic, busy, done;
   logic [4:0]  cmp_idx;
   logic [15:0] conv_count;

   logic        w_start, w_cont;
   logic        w_seq_init, w_seq_samp, w_seq_cmp, w_seq_logic, w_busy, w_done;
   logic [4:0]  w_cmp_idx;
   logic [2:0]  w_conv_count;

   logic [26:0] obs;
   logic [26:0] exp_q[$];
   logic [2:0]  wq[$];
   logic [26:0] e;
   logic [15:0] exp_cc;
   int          n_vec;
   int          n_err;
   int          cyc;

   assign obs = {seq_init, seq_samp, seq_cmp, seq_logic, busy, done, cmp_idx, conv_count};

   frida_seq_gen dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_cont(cfg_cont),
      .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp), .cfg_t_cmp(cfg_t_cmp),
      .cfg_t_logic(cfg_t_logic), .cfg_ncmp(cfg_ncmp),
      .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp), .seq_logic(seq_logic),
      .cmp_idx(cmp_idx), .busy(busy), .done(done), .conv_count(conv_count)
   );

   frida_seq_gen #(.CONV_W(3)) dut_wrap (
      .clk(clk), .rst(rst), .start(w_start), .abort(1'b0), .cfg_cont(w_cont),
      .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp), .cfg_t_cmp(cfg_t_cmp),
      .cfg_t_logic(cfg_t_logic), .cfg_ncmp(cfg_ncmp),
      .seq_init(w_seq_init), .seq_samp(w_seq_samp), .seq_cmp(w_seq_cmp), .seq_logic(w_seq_logic),
      .cmp_idx(w_cmp_idx), .busy(w_busy), .done(w_done), .conv_count(w_conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic logic [26:0] mk(input logic [3:0] seq, input logic b, input logic d,
                                      input logic [4:0] idx, input logic [15:0] cc);
      return {seq, b, d, idx, cc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected vectors for one conversion's busy cycles. done_first marks the
   // first INIT cycle as the done cycle of a preceding continuous conversion.
   task automatic gen_conv(input int ti, input int ts, input int tc, input int tl,
                           input int nc, input bit done_first, input logic [15:0] cc);
      for (int i = 0; i < ti; i++) exp_q.push_back(mk(4'b1000, 1'b1, done_first && (i == 0), 5'd0, cc));
      for (int i = 0; i < ts; i++) exp_q.push_back(mk(4'b0100, 1'b1, 1'b0, 5'(nc - 1), cc));
      for (int k = nc - 1; k >= 0; k--) begin
         for (int i = 0; i < tc; i++) exp_q.push_back(mk(4'b0010, 1'b1, 1'b0, 5'(k), cc));
         for (int i = 0; i < tl; i++) exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, 5'(k), cc));
      end
   endtask

   task automatic set_cfg(input int ti, input int ts, input int tc, input int tl, input int nc, input bit ct);
      cfg_t_init  = 8'(ti);
      cfg_t_samp  = 8'(ts);
      cfg_t_cmp   = 8'(tc);
      cfg_t_logic = 8'(tl);
      cfg_ncmp    = 5'(nc);
      cfg_cont    = ct;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b0;
      w_start = 1'b0; w_cont = 1'b0;
      set_cfg(1, 1, 1, 1, 1, 1'b0);
      exp_cc = 16'd0;
      exp_q.delete();
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, 16'd0));
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, 16'd0));
      tick(); tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_hold: got %h required %h", obs, e); end
      rst = 1'b0; start = 1'b0;
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_idle: got %h required %h", obs, e); end
   endtask

   task automatic test_basic();
      set_cfg(2, 3, 1, 1, 4, 1'b0);
      exp_q.delete();
      gen_conv(2, 3, 1, 1, 4, 1'b0, exp_cc);
      exp_cc++;
      exp_q.push_back(mk(4'b0, 1'b0, 1'b1, 5'd0, exp_cc));
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL basic cyc %0d: got %h required %h", cyc, obs, e); end
         tick(); cyc++;
      end
   endtask

   task automatic test_zero_clamp();
      set_cfg(0, 0, 0, 0, 0, 1'b0);
      exp_q.delete();
      gen_conv(1, 1, 1, 1, 1, 1'b0, exp_cc);
      exp_cc++;
      exp_q.push_back(mk(4'b0, 1'b0, 1'b1, 5'd0, exp_cc));
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL zero_clamp cyc %0d: got %h required %h", cyc, obs, e); end
         tick(); cyc++;
      end
   endtask

   task automatic test_cont();
      set_cfg(1, 1, 1, 1, 2, 1'b1);
      exp_q.delete();
      gen_conv(1, 1, 1, 1, 2, 1'b0, exp_cc);
      exp_cc++;
      gen_conv(1, 1, 1, 1, 2, 1'b1, exp_cc);
      exp_cc++;
      gen_conv(1, 1, 1, 1, 2, 1'b1, exp_cc);
      exp_cc++;
      exp_q.push_back(mk(4'b0, 1'b0, 1'b1, 5'd0, exp_cc));
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL cont cyc %0d: got %h required %h", cyc, obs, e); end
         // Third conversion starts at cycle 12; clearing here ends the loop after it.
         if (cyc == 12) cfg_cont = 1'b0;
         tick(); cyc++;
      end
   endtask

   task automatic test_abort();
      for (int r = 0; r < 2; r++) begin
         // Run 0: abort in first cycle of the second CMP phase (cycle 5).
         // Run 1: abort during the final LOGIC cycle (cycle 5).
         if (r == 0) set_cfg(1, 1, 2, 1, 3, 1'b0);
         else        set_cfg(1, 1, 1, 1, 2, 1'b0);
         exp_q.delete();
         if (r == 0) gen_conv(1, 1, 2, 1, 3, 1'b0, exp_cc);
         else        gen_conv(1, 1, 1, 1, 2, 1'b0, exp_cc);
         while (exp_q.size() > 6) void'(exp_q.pop_back());
         exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
         exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
         start = 1'b1; tick(); start = 1'b0;
         cyc = 0;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL abort%0d cyc %0d: got %h required %h", r, cyc, obs, e); end
            abort = (cyc == 5);
            tick(); cyc++;
         end
         abort = 1'b0;
      end
      // Abort and start together in IDLE: abort wins.
      exp_q.delete();
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL abort_start_idle: got %h required %h", obs, e); end
      // Clean conversion after the aborts.
      set_cfg(1, 2, 1, 2, 2, 1'b0);
      gen_conv(1, 2, 1, 2, 2, 1'b0, exp_cc);
      exp_cc++;
      exp_q.push_back(mk(4'b0, 1'b0, 1'b1, 5'd0, exp_cc));
      exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL abort_recover cyc %0d: got %h required %h", cyc, obs, e); end
         tick(); cyc++;
      end
   endtask

   task automatic test_cfg_latch();
      for (int r = 0; r < 2; r++) begin
         if (r == 0) set_cfg(2, 3, 1, 1, 1, 1'b0);
         exp_q.delete();
         gen_conv(2, (r == 0) ? 3 : 7, 1, 1, 1, 1'b0, exp_cc);
         exp_cc++;
         exp_q.push_back(mk(4'b0, 1'b0, 1'b1, 5'd0, exp_cc));
         exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, exp_cc));
         start = 1'b1; tick(); start = 1'b0;
         cyc = 0;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL cfg_latch%0d cyc %0d: got %h required %h", r, cyc, obs, e); end
            if (r == 0 && cyc == 0) cfg_t_samp = 8'd7;
            tick(); cyc++;
         end
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(1, 5, 1, 1, 1, 1'b0);
      exp_q.delete();
      exp_q.push_back(mk(4'b0100, 1'b1, 1'b0, 5'd0, exp_cc));
      exp_cc = 16'd0;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(4'b0, 1'b0, 1'b0, 5'd0, 16'd0));
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rst_mid_pre: got %h required %h", obs, e); end
      #3;
      rst = 1'b1; start = 1'b1;
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rst_mid_async: got %h required %h", obs, e); end
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_q.pop_front(); n_vec++;
         if (obs !== e) begin n_err++; $display("FAIL rst_mid_hold%0d: got %h required %h", i, obs, e); end
      end
      rst = 1'b0; start = 1'b0;
      tick();
      e = exp_q.pop_front(); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL rst_mid_release: got %h required %h", obs, e); end
   endtask

   task automatic test_wrap();
      int  wait_cnt;
      logic [2:0] ew;
      set_cfg(0, 0, 0, 0, 0, 1'b0);
      wq.delete();
      for (int k = 1; k <= 10; k++) wq.push_back(3'(k % 8));
      w_cont = 1'b1;
      w_start = 1'b1; tick(); w_start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         wait_cnt = 0;
         while (w_done !== 1'b1 && wait_cnt < 20) begin tick(); wait_cnt++; end
         ew = wq.pop_front(); n_vec++;
         if (w_done !== 1'b1) begin
            n_err++; $display("FAIL wrap_timeout conv %0d: got no done required done", k);
         end else if (w_conv_count !== ew) begin
            n_err++; $display("FAIL wrap_count conv %0d: got %0d required %0d", k, w_conv_count, ew);
         end
         if (k == 9) w_cont = 1'b0;
         tick();
      end
      tick();
      n_vec++;
      if (w_busy !== 1'b0) begin n_err++; $display("FAIL wrap_idle: got busy %b required 0", w_busy); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_zero_clamp();
      test_cont();
      test_abort();
      test_cfg_latch();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frida_seq_gen.md
Name: frida_seq_gen

Overview:
On-chip conversion sequencer that generates the four SAR phase strobes `seq_init`, `seq_samp`, `seq_cmp` and `seq_logic` from a single fast clock. These are the strobes the core's ADC array consumes. It sits directly upstream of the core, as an alternative to driving the strobes off-chip through the LVDS RX pads. Phase widths and the compare-cycle count are programmable; single-shot and continuous modes are supported.

Parameters:
- CNT_W, 8, width of every phase-width field and of the phase counter.
- NCMP_W, 5, width of the compare-cycle count field (max 31 compare cycles).
- CONV_W, 16, width of the completed-conversion counter.

Ports:
- `clk`, in, 1: sequencer clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a conversion; sampled only in IDLE.
- `abort`, in, 1: synchronous stop; highest priority after reset.
- `cfg_cont`, in, 1: continuous mode; after a conversion completes, loop back to INIT.
- `cfg_t_init`, in, CNT_W: INIT phase width in clk cycles.
- `cfg_t_samp`, in, CNT_W: SAMP phase width.
- `cfg_t_cmp`, in, CNT_W: CMP phase width.
- `cfg_t_logic`, in, CNT_W: LOGIC phase width.
- `cfg_ncmp`, in, NCMP_W: number of CMP/LOGIC pairs per conversion.
- `seq_init`, out, 1: init strobe to the ADC array.
- `seq_samp`, out, 1: sample strobe.
- `seq_cmp`, out, 1: comparator strobe.
- `seq_logic`, out, 1: SAR update-logic strobe.
- `cmp_idx`, out, NCMP_W: index of the current compare cycle, counting down from ncmp-1 to 0.
- `busy`, out, 1: high while any phase is active.
- `done`, out, 1: one-cycle pulse at the end of each conversion.
- `conv_count`, out, CONV_W: count of completed conversions; wraps at full scale.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including `cmp_idx` and `conv_count`. Latched config is cleared.
- Output registering: all `seq_*`, `busy` and `done` are driven directly from flops, with no combinational decode to the outputs.
  - `seq_*` are mutually exclusive and one-hot-or-zero in every cycle.
- FSM states: IDLE, INIT, SAMP, CMP, LOGIC.
- Configuration latch: all `cfg_*` values are latched on the edge that leaves IDLE and again on each continuous-mode re-entry to INIT. Config changes mid-conversion have no effect.
- Zero-value clamps: any phase width of 0 is treated as 1. A `cfg_ncmp` of 0 is treated as 1.
- IDLE -> INIT: when `start`=1 at a rising edge.
  - `seq_init` and `busy` go high in the following cycle. Latency from `start` to strobe is 1 cycle.
- Phase durations: each phase's strobe stays high for exactly its latched width.
  - The next phase's strobe is high in the immediately following cycle; there are no gap cycles.
- Phase order: INIT -> SAMP -> CMP -> LOGIC.
  - After LOGIC, if `cmp_idx`!=0: decrement `cmp_idx` and go to CMP.
  - After LOGIC, if `cmp_idx`=0: the conversion is complete.
- `cmp_idx` timing: loaded with ncmp-1 when SAMP is entered. It holds its value through each CMP+LOGIC pair and is 0 in IDLE.
- Conversion complete:
  - `done`=1 for exactly one cycle, namely the cycle immediately after the last `seq_logic` cycle.
  - `conv_count` increments in that same cycle. At full scale it wraps to 0 without saturating.
- After completion, continuous mode (`cfg_cont`=1):
  - The `done` cycle is also the first `seq_init` cycle.
  - `busy` stays high continuously.
  - `cfg_cont` is sampled live, i.e. not latched.
- After completion, single-shot mode (`cfg_cont`=0): go to IDLE, with `busy`=0 in the `done` cycle.
- `start` outside IDLE is ignored.
- `abort`=1 at any edge, in any state:
  - FSM goes to IDLE and all `seq_*`, `busy`, `done` and `cmp_idx` go to 0 in the next cycle.
  - `conv_count` is unchanged; a partial conversion is never counted.
- Simultaneous `abort` and `start` in IDLE: `abort` wins and the FSM stays in IDLE.
- Simultaneous `abort` and conversion completion: no `done` pulse and no count increment.
- Async `rst` mid-operation: all strobes drop immediately, without waiting for a clock edge.
- Total `busy` duration of one single-shot conversion is t_init + t_samp + ncmp × (t_cmp + t_logic) cycles.

Test Plan:
- Basic timing:
  - Stimulus: t_init=2, t_samp=3, t_cmp=1, t_logic=1, ncmp=4, `cfg_cont`=0; pulse `start`.
  - Expect: `seq_init` high 2 cycles, then `seq_samp` high 3, then 4 alternating cmp/logic pairs; `cmp_idx` reads 3, 2, 1, 0.
  - Expect: `busy` high for 13 cycles; `done` pulses once in the cycle after the last `seq_logic`; `conv_count`=1; then IDLE.
- Zero clamps:
  - Stimulus: all widths 0, `ncmp`=0.
  - Expect: each strobe high for 1 cycle (init, samp, cmp, logic); `busy` high for 4 cycles; `done` pulses once.
- Continuous mode:
  - Stimulus: `cfg_cont`=1, widths 1, ncmp=2; run 3 conversions, then clear `cfg_cont`.
  - Expect: `busy` never drops between conversions.
  - Expect: `done` coincides with `seq_init` on each loop; `conv_count` increments once per conversion; the FSM reaches IDLE after the loop in which `cfg_cont` is observed 0.
- Abort:
  - Stimulus: assert `abort` during the second CMP phase; in a separate run, assert it in the same cycle as the final LOGIC cycle.
  - Expect: all strobes low in the next cycle and no `done` pulse.
  - Expect: `conv_count` unchanged in both runs; a new `start` afterwards produces a clean sequence.
- Config latch:
  - Stimulus: change `cfg_t_samp` from 3 to 7 during INIT.
  - Expect: SAMP still lasts 3 cycles; the next conversion uses 7.
- Reset and wrap:
  - Stimulus: assert `rst` mid-SAMP, between clock edges.
  - Expect: all outputs 0 immediately; `start` ignored while `rst` is high.
  - Stimulus: preload `conv_count` to 0xFFFF with CONV_W=16 and complete one conversion.
  - Expect: `conv_count` wraps to 0x0000.
